star_accumulator: RTL

- Receiver and consumer of the exp-multiply stage output stream.
- Sums MAX_SEQ_LENGTH consecutive rescaled star vectors (Q9.17, MAX_EMBEDDING_DIM+1 lanes, lane 0 = denominator) into one per-query result.
- Presents the result downstream on a valid/ready interface.
- Sits between the exp-multiply stage and the normalization/writeback stage; a one-entry output buffer lets the next query accumulate while the previous result waits.

---
 rtl/star_accumulator.sv | 105 ++++++++++
 1 files changed

// File: rtl/star_accumulator.sv
// Sums SEQ_LEN rescaled star vectors per query; result valid 1 cycle after last-beat accept, held in a 1-entry buffer.
// Only the completing beat stalls while the buffer is full and not draining. STAR_ACC_SAT_EN selects saturating lane adds.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 3
`endif
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 4
`endif

module star_accumulator #(
    parameter int DIM     = `MAX_EMBEDDING_DIM + 1,
    parameter int VEC_W   = 26,
    parameter int SEQ_LEN = `MAX_SEQ_LENGTH,
    localparam int CNT_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   vld_in,
    output logic                   rdy_out,
    input  logic [DIM*VEC_W-1:0]   v_in,
    output logic                   vld_out,
    input  logic                   rdy_in,
    output logic [DIM*VEC_W-1:0]   v_out,
    output logic [CNT_W-1:0]       beat_count,
    output logic                   busy
);

    logic [DIM*VEC_W-1:0] acc_q, acc_d;
    logic [DIM*VEC_W-1:0] v_out_q, v_out_d;
    logic                 vld_out_q, vld_out_d;
    logic [CNT_W-1:0]     beat_count_q, beat_count_d;

    logic                 last;
    logic                 accept;
    logic [VEC_W-1:0]     base;
    logic [DIM*VEC_W-1:0] sum;

    function automatic logic [VEC_W-1:0] lane_add(input logic [VEC_W-1:0] a,
                                                  input logic [VEC_W-1:0] b);
`ifdef STAR_ACC_SAT_EN
        logic [VEC_W:0] s;
        s = {a[VEC_W-1], a} + {b[VEC_W-1], b};
        // Top two bits disagree only when the true sum left the VEC_W range.
        if (s[VEC_W] != s[VEC_W-1])
            lane_add = s[VEC_W] ? {1'b1, {(VEC_W-1){1'b0}}} : {1'b0, {(VEC_W-1){1'b1}}};
        else
            lane_add = s[VEC_W-1:0];
`else
        lane_add = a + b;
`endif
    endfunction

    always_comb begin
        last    = (beat_count_q == CNT_W'(SEQ_LEN - 1));
        rdy_out = !(vld_out_q && !rdy_in && last);
        accept  = vld_in && rdy_out;

        // First beat of a query starts from zero so no stale sum leaks in.
        base = '0;
        sum  = '0;
        for (int i = 0; i < DIM; i++) begin
            base = (beat_count_q == '0) ? '0 : acc_q[i*VEC_W +: VEC_W];
            sum[i*VEC_W +: VEC_W] = lane_add(base, v_in[i*VEC_W +: VEC_W]);
        end

        acc_d        = acc_q;
        beat_count_d = beat_count_q;
        v_out_d      = v_out_q;
        vld_out_d    = vld_out_q;

        if (vld_out_q && rdy_in)
            vld_out_d = 1'b0;

        if (accept) begin
            acc_d = sum;
            if (last) begin
                beat_count_d = '0;
                v_out_d      = sum;
                vld_out_d    = 1'b1;
            end else begin
                beat_count_d = beat_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q        <= '0;
            v_out_q      <= '0;
            vld_out_q    <= 1'b0;
            beat_count_q <= '0;
        end else begin
            acc_q        <= acc_d;
            v_out_q      <= v_out_d;
            vld_out_q    <= vld_out_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign vld_out    = vld_out_q;
    assign v_out      = v_out_q;
    assign beat_count = beat_count_q;
    assign busy       = (beat_count_q != '0);

endmodule
